// File: rtl/pi_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the PI duty controller.
package pi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ERR   = 3'd1;
  localparam state_t S_PROP  = 3'd2;
  localparam state_t S_INTEG = 3'd3;
  localparam state_t S_SUM   = 3'd4;
  localparam state_t S_OUT   = 3'd5;

  localparam int DUTY_MAX_DEF = 250;
  localparam int PWM_SCALE    = 40;

  // Signed width needed to hold +/-(duty_max << frac), the integrator bound.
  function automatic int integ_limit_width(input int duty_max, input int frac);
    return $clog2(duty_max + 1) + frac + 1;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Signed saturating clamp of a W-bit two's-complement value into [LO, HI], resized to OW bits.
module sat_clamp #(
  parameter int W  = 16,
  parameter int OW = 16,
  parameter int LO = 0,
  parameter int HI = 255
) (
  input  logic [W-1:0]  value,
  output logic [OW-1:0] result
);

  localparam logic signed [W-1:0] LO_S = W'(LO);
  localparam logic signed [W-1:0] HI_S = W'(HI);

  logic signed [W-1:0] v;
  logic signed [W-1:0] sel;

  always_comb begin
    v = $signed(value);
    if (v < LO_S)
      sel = LO_S;
    else if (v > HI_S)
      sel = HI_S;
    else
      sel = v;
    result = OW'(sel);
  end

endmodule

// File: rtl/pi_duty_controller.sv
// Multicycle PI controller producing a clamped PWM duty command once per sample strobe,
// with an anti-windup integrator bounded to +/-(DUTY_MAX << FRAC).
module pi_duty_controller
  import pi_pkg::*;
#(
  parameter int TP       = 8,
  parameter int N_in     = 8,
  parameter int KP       = 16,
  parameter int KI       = 2,
  parameter int FRAC     = 4,
  parameter int DUTY_MAX = DUTY_MAX_DEF,
  parameter int ACC_W    = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sample_valid,
  input  logic [N_in-1:0] setpoint,
  input  logic [N_in-1:0] measurement,
  output logic [TP-1:0]   duty,
  output logic            duty_valid,
  output logic            busy
);

  localparam int KP_W   = $clog2(KP + 1) + 1;
  localparam int KI_W   = $clog2(KI + 1) + 1;
  localparam int P_W    = KP_W + N_in + 1;
  localparam int KT_W   = KI_W + N_in + 1;
  localparam int LIM_W  = integ_limit_width(DUTY_MAX, FRAC);
  localparam int MAX_IW = (ACC_W > KT_W) ? ((ACC_W > LIM_W) ? ACC_W : LIM_W)
                                         : ((KT_W > LIM_W) ? KT_W : LIM_W);
  // One guard bit over the widest operand so integ + KI*e cannot wrap before clamping.
  localparam int NEXT_W = MAX_IW + 1;
  localparam int SUM_W  = ((P_W > ACC_W) ? P_W : ACC_W) + 1;
  localparam int ILIM   = DUTY_MAX << FRAC;

  localparam logic signed [KP_W-1:0] KP_S = KP_W'(KP);
  localparam logic signed [KI_W-1:0] KI_S = KI_W'(KI);

  state_t                    state;
  logic signed [N_in:0]      e;
  logic signed [P_W-1:0]     p;
  logic signed [NEXT_W-1:0]  integ_next;
  logic signed [ACC_W-1:0]   integ;
  logic [TP-1:0]             u;

  logic signed [KT_W-1:0]    ki_term;
  logic signed [SUM_W-1:0]   sum_full;
  logic signed [SUM_W-1:0]   sum_shift;
  logic [ACC_W-1:0]          integ_clamped;
  logic [TP-1:0]             u_clamped;

  assign ki_term   = KI_S * e;
  assign sum_full  = SUM_W'(p) + SUM_W'(integ);
  assign sum_shift = sum_full >>> FRAC;
  assign busy      = (state != S_IDLE);

  sat_clamp #(.W(NEXT_W), .OW(ACC_W), .LO(-ILIM), .HI(ILIM)) integ_clamp (
    .value  (integ_next),
    .result (integ_clamped)
  );

  sat_clamp #(.W(SUM_W), .OW(TP), .LO(0), .HI(DUTY_MAX)) out_clamp (
    .value  (sum_shift),
    .result (u_clamped)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      e          <= '0;
      p          <= '0;
      integ_next <= '0;
      integ      <= '0;
      u          <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            e     <= $signed({1'b0, setpoint}) - $signed({1'b0, measurement});
            state <= S_ERR;
          end
        end
        S_ERR: begin
          p     <= KP_S * e;
          state <= S_PROP;
        end
        S_PROP: begin
          integ_next <= NEXT_W'(integ) + NEXT_W'(ki_term);
          state      <= S_INTEG;
        end
        S_INTEG: begin
          integ <= $signed(integ_clamped);
          state <= S_SUM;
        end
        S_SUM: begin
          u     <= u_clamped;
          state <= S_OUT;
        end
        S_OUT: begin
          duty       <= u;
          duty_valid <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_duty_controller.sv
// Directed self-checking bench for pi_duty_controller using hand-computed PI results.
module tb_pi_duty_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] setpoint = '0;
  logic [7:0] measurement = '0;
  logic [7:0] duty;
  logic       duty_valid;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pi_duty_controller dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .setpoint     (setpoint),
    .measurement  (measurement),
    .duty         (duty),
    .duty_valid   (duty_valid),
    .busy         (busy)
  );

  task automatic check_output(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  function automatic int integ_now();
    return int'($signed(dut.integ));
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the falling edge just after the strobe was sampled (edge N).
  task automatic apply_stimulus(input int sp, input int meas);
    @(negedge clk);
    sample_valid = 1'b1;
    setpoint = 8'(sp);
    measurement = 8'(meas);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic run_sample(input string tag, input int sp, input int meas,
                            input int exp_duty, input int exp_integ);
    apply_stimulus(sp, meas);
    check_output({tag, "_busy_n"}, int'(busy), 1);
    repeat (4) @(negedge clk);
    check_output({tag, "_dv_n4"}, int'(duty_valid), 0);
    @(negedge clk);
    check_output({tag, "_dv_n5"}, int'(duty_valid), 1);
    check_output({tag, "_duty"}, int'(duty), exp_duty);
    check_output({tag, "_integ"}, integ_now(), exp_integ);
    @(negedge clk);
    check_output({tag, "_dv_n6"}, int'(duty_valid), 0);
    check_output({tag, "_idle_n6"}, int'(busy), 0);
  endtask

  initial begin
    int pulses;
    int exp_i;

    // Reset values
    apply_reset();
    check_output("rst_duty", int'(duty), 0);
    check_output("rst_dv", int'(duty_valid), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_integ", integ_now(), 0);

    // Basic PI step and accumulation
    run_sample("basic1", 100, 50, 56, 100);
    run_sample("basic2", 100, 50, 62, 200);

    // Output saturates high
    apply_reset();
    run_sample("sat_hi", 255, 0, 250, 510);

    // Integrator anti-windup at the negative bound
    apply_reset();
    for (int k = 1; k <= 11; k++) begin
      exp_i = -400 * k;
      if (exp_i < -4000) exp_i = -4000;
      run_sample("windup", 0, 200, 0, exp_i);
    end
    run_sample("unwind", 200, 0, 0, -3600);

    // Strobe while busy is ignored; strobe at N+6 is accepted
    apply_reset();
    @(negedge clk);
    sample_valid = 1'b1; setpoint = 8'd100; measurement = 8'd50;
    @(negedge clk);
    sample_valid = 1'b0;
    pulses = 0;
    @(negedge clk);
    sample_valid = 1'b1; setpoint = 8'd255; measurement = 8'd0;
    @(negedge clk);
    sample_valid = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk);
      if (duty_valid) pulses++;
    end
    check_output("busy_pulses", pulses, 1);
    check_output("busy_duty", int'(duty), 56);
    check_output("busy_integ", integ_now(), 100);
    sample_valid = 1'b1; setpoint = 8'd100; measurement = 8'd50;
    @(negedge clk);
    sample_valid = 1'b0;
    check_output("n6_accept_busy", int'(busy), 1);
    check_output("n6_dv", int'(duty_valid), 0);
    repeat (4) @(negedge clk);
    check_output("n6_dv_pre", int'(duty_valid), 0);
    @(negedge clk);
    check_output("n6_dv_n5", int'(duty_valid), 1);
    check_output("n6_duty", int'(duty), 62);
    check_output("n6_integ", integ_now(), 200);

    // Asynchronous reset in the INTEG cycle discards the sample
    apply_reset();
    run_sample("pre_abort", 100, 50, 56, 100);
    apply_stimulus(100, 50);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("abort_duty", int'(duty), 0);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_integ", integ_now(), 0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (duty_valid || busy) pulses++;
    end
    check_output("abort_quiet", pulses, 0);
    run_sample("post_abort", 100, 50, 56, 100);

    // Zero error leaves everything at zero
    apply_reset();
    run_sample("zero_err", 120, 120, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
